// File: rtl/pma_tx_symb_buffer.sv
// Elastic buffer between the PCS transmit encoder and the PMA transmit path.
// Primes to PRIME entries, then releases one symbol vector per symbol-timer tick.
module pma_tx_symb_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PRIME  = 2,
  parameter int unsigned SYMB_W = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_in_valid,
  output logic                         io_in_ready,
  input  logic [SYMB_W-1:0]            io_in_bits_0,
  input  logic [SYMB_W-1:0]            io_in_bits_1,
  input  logic [SYMB_W-1:0]            io_in_bits_2,
  input  logic [SYMB_W-1:0]            io_in_bits_3,
  input  logic                         io_symb_timer_done,
  input  logic                         io_flush,
  output logic                         io_out_valid,
  output logic [SYMB_W-1:0]            io_out_bits_0,
  output logic [SYMB_W-1:0]            io_out_bits_1,
  output logic [SYMB_W-1:0]            io_out_bits_2,
  output logic [SYMB_W-1:0]            io_out_bits_3,
  output logic                         io_underflow,
  output logic                         io_running,
  output logic [$clog2(DEPTH+1)-1:0]   io_level,
  output logic [15:0]                  io_underflow_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam int unsigned VecW = 4 * SYMB_W;

  typedef enum logic {StFill, StRun} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [VecW-1:0] out_bits_q, out_bits_d;
  logic            out_valid_q, out_valid_d;
  logic            underflow_q, underflow_d;
  logic [15:0]     count_q, count_d;
  logic [VecW-1:0] mem_q [DEPTH];

  logic [VecW-1:0] in_vec;
  logic            in_ready, push, pop, underflow, run_eff, has_data, tick;

  assign in_vec = {io_in_bits_3, io_in_bits_2, io_in_bits_1, io_in_bits_0};
  assign tick   = io_symb_timer_done && !io_flush;

  always_comb begin
    in_ready    = level_q < LvlW'(DEPTH);
    has_data    = level_q != '0;
    push        = io_in_valid && in_ready && !io_flush;
    // The FILL->RUN decision precedes the tick action, so a priming tick pops.
    run_eff     = (state_q == StRun) || (level_q >= LvlW'(PRIME));
    pop         = tick && run_eff && has_data;
    underflow   = tick && (state_q == StRun) && !has_data;

    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    level_d     = level_q;
    out_bits_d  = out_bits_q;
    out_valid_d = io_symb_timer_done;
    underflow_d = underflow;
    count_d     = count_q;

    if (io_flush) begin
      state_d = StFill;
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      level_d = level_q + LvlW'(push) - LvlW'(pop);
      if (underflow) begin
        state_d = StFill;
      end else if (run_eff) begin
        state_d = StRun;
      end
    end

    if (io_symb_timer_done) begin
      out_bits_d = pop ? mem_q[head_q] : '0;
    end

    if (underflow && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StFill;
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= in_vec;
    end
  end

  assign io_in_ready        = in_ready;
  assign io_out_valid       = out_valid_q;
  assign io_out_bits_0      = out_bits_q[0*SYMB_W +: SYMB_W];
  assign io_out_bits_1      = out_bits_q[1*SYMB_W +: SYMB_W];
  assign io_out_bits_2      = out_bits_q[2*SYMB_W +: SYMB_W];
  assign io_out_bits_3      = out_bits_q[3*SYMB_W +: SYMB_W];
  assign io_underflow       = underflow_q;
  assign io_running         = state_q == StRun;
  assign io_level           = level_q;
  assign io_underflow_count = count_q;

endmodule

// File: tb/tb_pma_tx_symb_buffer.sv
// Directed bench for pma_tx_symb_buffer: scoreboard of expected vectors, immediate assertions.
module tb_pma_tx_symb_buffer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Main instance (DEPTH 8, PRIME 2)
  logic        in_valid = 1'b0, tick = 1'b0, flush = 1'b0;
  logic [11:0] in_vec = '0;
  logic        in_ready, out_valid, underflow, running;
  logic [2:0]  ob0, ob1, ob2, ob3;
  logic [3:0]  level;
  logic [15:0] ucount;
  logic [11:0] out_vec;
  assign out_vec = {ob3, ob2, ob1, ob0};

  pma_tx_symb_buffer #(.DEPTH(8), .PRIME(2), .SYMB_W(3)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (in_valid),
    .io_in_ready        (in_ready),
    .io_in_bits_0       (in_vec[2:0]),
    .io_in_bits_1       (in_vec[5:3]),
    .io_in_bits_2       (in_vec[8:6]),
    .io_in_bits_3       (in_vec[11:9]),
    .io_symb_timer_done (tick),
    .io_flush           (flush),
    .io_out_valid       (out_valid),
    .io_out_bits_0      (ob0),
    .io_out_bits_1      (ob1),
    .io_out_bits_2      (ob2),
    .io_out_bits_3      (ob3),
    .io_underflow       (underflow),
    .io_running         (running),
    .io_level           (level),
    .io_underflow_count (ucount)
  );

  // Second instance (PRIME 1) gives the fastest underflow cadence for saturation.
  logic        s_valid = 1'b0, s_tick = 1'b0;
  logic [11:0] s_vec = 12'h001;
  logic        s_ready, s_out_valid, s_underflow, s_running;
  logic [2:0]  s_ob0, s_ob1, s_ob2, s_ob3;
  logic [3:0]  s_level;
  logic [15:0] s_count;

  pma_tx_symb_buffer #(.DEPTH(8), .PRIME(1), .SYMB_W(3)) dut_sat (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (s_valid),
    .io_in_ready        (s_ready),
    .io_in_bits_0       (s_vec[2:0]),
    .io_in_bits_1       (s_vec[5:3]),
    .io_in_bits_2       (s_vec[8:6]),
    .io_in_bits_3       (s_vec[11:9]),
    .io_symb_timer_done (s_tick),
    .io_flush           (1'b0),
    .io_out_valid       (s_out_valid),
    .io_out_bits_0      (s_ob0),
    .io_out_bits_1      (s_ob1),
    .io_out_bits_2      (s_ob2),
    .io_out_bits_3      (s_ob3),
    .io_underflow       (s_underflow),
    .io_running         (s_running),
    .io_level           (s_level),
    .io_underflow_count (s_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [11:0] sb[$];

  function automatic logic [11:0] mk(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Distinct for k < 64 because lanes A,B carry k directly.
  function automatic logic [11:0] vec(input int k);
    logic [5:0] kk;
    logic [2:0] c;
    kk = k[5:0];
    c  = kk[2:0] + 3'd3;
    return {~kk[2:0], c, kk[5:3], kk[2:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic push_vec(input logic [11:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    chk("in_ready_before_push", 32'(in_ready), 32'd1);
    sb.push_back(v);
    edge1();
    in_valid = 1'b0;
  endtask

  // Check the vector released on the tick just taken against the scoreboard head.
  task automatic check_pop(input string tag);
    logic [11:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bits"}, 32'(out_vec), 32'(e));
      chk({tag, "_no_underflow"}, 32'(underflow), 32'd0);
    end
  endtask

  task automatic tick_pop(input string tag);
    tick = 1'b1;
    edge1();
    tick = 1'b0;
    check_pop(tag);
  endtask

  task automatic run_sat(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      s_valid = (i % 2) == 0;
      edge1();
    end
  endtask

  initial begin
    // Reset state
    edge1();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", 32'(out_vec), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_count", 32'(ucount), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // FILL ticks with an empty buffer emit zeros without underflow
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      edge1();
      tick = 1'b0;
      chk("fill_tick_valid", 32'(out_valid), 32'd1);
      chk("fill_tick_bits", 32'(out_vec), 32'd0);
      chk("fill_tick_underflow", 32'(underflow), 32'd0);
      chk("fill_tick_count", 32'(ucount), 32'd0);
      chk("fill_tick_running", 32'(running), 32'd0);
    end
    edge1();
    chk("no_tick_valid_low", 32'(out_valid), 32'd0);

    // Prime with two vectors, then the first tick both enters RUN and pops
    push_vec(mk(1, 2, 3, 4));
    chk("prime_level1", 32'(level), 32'd1);
    chk("prime_not_running1", 32'(running), 32'd0);
    push_vec(mk(-1, -2, 0, 1));
    chk("prime_level2", 32'(level), 32'd2);
    chk("prime_not_running2", 32'(running), 32'd0);
    tick_pop("prime_first");
    chk("prime_running", 32'(running), 32'd1);
    chk("prime_level_after_pop", 32'(level), 32'd1);
    edge1();
    chk("hold_valid_low", 32'(out_valid), 32'd0);
    chk("hold_bits", 32'(out_vec), 32'(mk(1, 2, 3, 4)));
    tick_pop("prime_second");
    chk("drained_level", 32'(level), 32'd0);

    // Underflow in RUN with a same-cycle push that must be retained
    in_valid = 1'b1;
    in_vec   = mk(3, -3, 2, -4);
    tick     = 1'b1;
    sb.push_back(in_vec);
    edge1();
    in_valid = 1'b0;
    tick     = 1'b0;
    chk("uf_valid", 32'(out_valid), 32'd1);
    chk("uf_bits", 32'(out_vec), 32'd0);
    chk("uf_pulse", 32'(underflow), 32'd1);
    chk("uf_count", 32'(ucount), 32'd1);
    chk("uf_running_falls", 32'(running), 32'd0);
    chk("uf_push_kept", 32'(level), 32'd1);
    edge1();
    chk("uf_pulse_one_cycle", 32'(underflow), 32'd0);

    // Fill to DEPTH, observe backpressure, then stream through pointer wrap
    for (int k = 0; k < 7; k++) push_vec(vec(k));
    chk("full_level", 32'(level), 32'd8);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    chk("full_running", 32'(running), 32'd1);
    in_valid = 1'b1;
    in_vec   = vec(7);
    edge1();
    chk("full_reject_level", 32'(level), 32'd8);
    tick = 1'b1;
    edge1();
    tick = 1'b0;
    check_pop("full_pop");
    chk("full_pop_level", 32'(level), 32'd7);
    chk("ready_returns", 32'(in_ready), 32'd1);
    for (int k = 7; k < 20; k++) begin
      in_valid = 1'b1;
      in_vec   = vec(k);
      tick     = 1'b1;
      sb.push_back(vec(k));
      edge1();
      check_pop("stream");
      chk("stream_level", 32'(level), 32'd7);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick_pop("drain");
    chk("drain_level", 32'(level), 32'd0);

    // Flush at level 5 with a coinciding push and tick
    for (int k = 20; k < 25; k++) push_vec(vec(k));
    chk("pre_flush_level", 32'(level), 32'd5);
    sb.delete();
    in_valid = 1'b1;
    in_vec   = vec(30);
    tick     = 1'b1;
    flush    = 1'b1;
    edge1();
    in_valid = 1'b0;
    tick     = 1'b0;
    flush    = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_running", 32'(running), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_bits", 32'(out_vec), 32'd0);
    chk("flush_no_underflow", 32'(underflow), 32'd0);
    chk("flush_count_kept", 32'(ucount), 32'd1);
    push_vec(vec(40));
    push_vec(vec(41));
    tick_pop("post_flush");
    chk("post_flush_running", 32'(running), 32'd1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_bits", 32'(out_vec), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_count", 32'(ucount), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sb.delete();

    // Saturation: one underflow every two cycles on the PRIME=1 instance
    s_tick = 1'b1;
    run_sat(0, 2 * 65534);
    chk("sat_count_fffe", 32'(s_count), 32'h0000_FFFE);
    run_sat(2 * 65534 + 1, 2 * 65535);
    chk("sat_count_ffff", 32'(s_count), 32'h0000_FFFF);
    run_sat(2 * 65535 + 1, 2 * 65540);
    chk("sat_count_sticks", 32'(s_count), 32'h0000_FFFF);
    chk("sat_pulse_still", 32'(s_underflow), 32'd1);
    s_tick  = 1'b0;
    s_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pma_tx_symb_buffer.md
Name: pma_tx_symb_buffer

Overview:
- Elastic buffer between the PCS transmit encoder (Encoder_TXRX_SM tx_symb_vector valid/ready output) and the PMA transmit path.
- Accepts 4-lane PAM5 symbol vectors (A,B,C,D, 3-bit two's complement each) on a valid/ready handshake.
- Releases exactly one vector per symbol-timer tick.
- Absorbs encoder/PMA rate jitter, primes before transmitting, substitutes zero symbols on underflow, and counts underflow events.

Parameters:
- DEPTH, 8, number of symbol-vector entries; power of two, ≥4.
- PRIME, 2, entries required in FILL before RUN starts; 1 ≤ PRIME ≤ DEPTH.
- SYMB_W, 3, width of one lane symbol.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  encoder offers a vector.
- io_in_ready  out  1  buffer can accept; high iff level < DEPTH.
- io_in_bits_0..3  in  SYMB_W each  lanes A..D.
- io_symb_timer_done  in  1  one-cycle symbol tick from PMA timer.
- io_flush  in  1  synchronous flush (pcs_reset / link drop).
- io_out_valid  out  1  one-cycle pulse when io_out_bits are updated.
- io_out_bits_0..3  out  SYMB_W each  registered lanes A..D to PMA; held between ticks.
- io_underflow  out  1  one-cycle pulse on an underflow tick.
- io_running  out  1  high while state == RUN.
- io_level  out  $clog2(DEPTH+1)  current occupancy.
- io_underflow_count  out  16  saturating underflow counter.

Behaviour:
- Reset (reset=0, async):
  - Pointers = 0, level = 0, state = FILL.
  - io_out_bits_* = 0, io_out_valid = 0, io_underflow = 0, io_underflow_count = 0.
  - io_in_ready = 1 once reset deasserts.
- Push: io_in_valid && io_in_ready at an edge writes the lanes to tail; tail wraps modulo DEPTH.
- io_in_ready is combinational from the registered level only. When full, no push is accepted even if a pop occurs in the same cycle.
- Pop: occurs only on a tick in RUN with level > 0.
  - Head entry → io_out_bits at that edge; io_out_valid = 1 for one cycle.
  - Latency: tick sampled at edge t → new bits and valid visible after edge t.
- Level update: level += push − pop. Simultaneous push and pop leaves level unchanged.
- FSM, FILL:
  - On a tick: io_out_bits ← 0 (all lanes), io_out_valid pulses, no pop, no underflow.
  - FILL → RUN at the edge where the registered level ≥ PRIME. The transition is evaluated before the tick action, so a tick in that same cycle already pops.
- FSM, RUN:
  - Tick with level > 0 → pop.
  - Tick with level == 0 → underflow:
    - io_out_bits ← 0; io_out_valid and io_underflow pulse.
    - io_underflow_count += 1, saturating at 0xFFFF.
    - State → FILL.
  - A push in the same cycle as an underflow tick is stored and does not cancel the underflow.
- Flush (synchronous, highest priority over push/pop/tick):
  - Level and pointers → 0, state → FILL, any input vector offered that cycle is dropped.
  - If a tick coincides: io_out_bits ← 0 and io_out_valid pulses; no underflow.
  - io_underflow_count is not cleared by flush, only by reset.
- io_running = (state == RUN). io_level = registered occupancy.
- No tick → io_out_bits held, io_out_valid = 0.
- Lane values pass bit-exact; no sign manipulation.

Test Plan:
1. Reset/prime: release reset, push vectors (1,2,3,4) and (−1,−2,0,1), then tick → running rises after level reaches 2.
   - First tick outputs (1,2,3,4) with out_valid pulse; next tick outputs (−1,−2,0,1).
2. Fill-state ticks: tick 3 times with the buffer empty after reset → three out_valid pulses, bits 0, io_underflow never asserts, count stays 0.
3. Full/backpressure: hold in_valid with io_symb_timer_done=0, pushing 8 distinct vectors.
   - in_ready drops when level=8; the 9th vector is not accepted.
   - One tick → in_ready returns the cycle after; FIFO order is preserved across pointer wrap over 20 vectors.
4. Underflow: in RUN, drain to level 0, then tick.
   - io_underflow pulses, bits = 0, count = 1, running falls.
   - Same-cycle push is held, level = 1.
5. Saturation: force 65540 underflow events → count sticks at 0xFFFF.
6. Flush mid-stream: level 5, assert io_flush with push and tick in the same cycle.
   - Level = 0, state FILL, out bits = 0, no underflow pulse, count unchanged.
   - Async reset asserted mid-stream → all outputs zero immediately, without waiting for a clock edge.
